// File: rtl/ahb3lite_sram_responder.sv
// AHB3-Lite SRAM responder: byte-lane writes, optional wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb3lite_sram_responder #(
    parameter int unsigned HADDR_SIZE  = 32,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic                  HMASTLOCK,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    input  logic                  HREADY,
    output logic                  HRESP
);
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NLANES = HDATA_SIZE / 8;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0]       idx_q, idx_d;
    logic [NLANES-1:0]       be_q, be_d;
    logic                    wr_q, wr_d;
    logic                    pend_q, pend_d;
    logic [HDATA_SIZE-1:0]   hrdata_q, hrdata_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;

    logic [HDATA_SIZE-1:0]   mem_q [MEM_DEPTH];

    logic                    accept_c;
    logic                    illegal_c;
    logic                    commit_c;
    logic [HADDR_SIZE-1:0]   word_idx_c;
    logic [MEM_AW-1:0]       idx_a_c;
    logic [NLANES-1:0]       be_c;
    logic [HDATA_SIZE-1:0]   mem_rd_q_c;
    logic [HDATA_SIZE-1:0]   mem_rd_a_c;
    logic [HDATA_SIZE-1:0]   merged_c;
    logic                    unused_c;

    assign unused_c   = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign word_idx_c = HADDR >> 2;
    assign idx_a_c    = HADDR[MEM_AW+1:2];
    assign mem_rd_q_c = mem_q[idx_q];
    assign mem_rd_a_c = mem_q[idx_a_c];

    // A new address phase is only taken in states that end a data phase.
    assign accept_c = HSEL && HREADY && HTRANS[1]
                   && (state_q inside {S_IDLE, S_DATA, S_ERR2});

    assign illegal_c = (word_idx_c >= HADDR_SIZE'(MEM_DEPTH))
                    || (HSIZE > SIZE_WORD)
                    || ((HSIZE == SIZE_HALF) && HADDR[0])
                    || ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));

    // Write data lands on the edge that closes a ready data phase; reset drops it.
    assign commit_c = HRESETn && wr_q
                   && ((state_q == S_DATA) || ((state_q == S_IDLE) && pend_q));

    always_comb begin
        be_c = '1;
        unique case (HSIZE)
            SIZE_BYTE: be_c = 4'b0001 << HADDR[1:0];
            SIZE_HALF: be_c = HADDR[1] ? 4'b1100 : 4'b0011;
            default:   be_c = '1;
        endcase
    end

    always_comb begin
        merged_c = mem_rd_q_c;
        for (int i = 0; i < NLANES; i++) begin
            if (be_q[i]) begin
                merged_c[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        be_d     = be_q;
        wr_d     = wr_q;
        pend_d   = 1'b0;
        hrdata_d = hrdata_q;

        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    if (!wr_q) begin
                        hrdata_d = mem_rd_q_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    idx_d = idx_a_c;
                    be_d  = be_c;
                    wr_d  = HWRITE && !illegal_c;
                    if (illegal_c) begin
                        state_d  = S_ERR1;
                        hrdata_d = '0;
                    end else if (WAIT_STATES == 0) begin
                        pend_d = 1'b1;
                        if (!HWRITE) begin
                            // A write to the same word closing on this edge is forwarded.
                            hrdata_d = (commit_c && (idx_q == idx_a_c)) ? merged_c : mem_rd_a_c;
                        end
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
        endcase

        hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
        hresp_d     = state_d inside {S_ERR1, S_ERR2};
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            pend_q      <= 1'b0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            be_q        <= be_d;
            wr_q        <= wr_d;
            pend_q      <= pend_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge HCLK) begin
        if (commit_c) begin
            mem_q[idx_q] <= merged_c;
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_responder.sv
// Scoreboard bench: three responders (0, 3 and 2 wait states) driven by a
// pipelined AHB master; a monitor checks each completed data phase.
`timescale 1ns/1ps
module tb_ahb3lite_sram_responder;
    localparam int NDUT = 3;

    localparam logic       W     = 1'b1;
    localparam logic       R     = 1'b0;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [1:0] T_IDL = 2'b00;
    localparam logic [1:0] T_BSY = 2'b01;
    localparam logic [1:0] T_NS  = 2'b10;
    localparam logic [1:0] T_SQ  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        hsel      [NDUT];
    logic [1:0]  htrans    [NDUT];
    logic [2:0]  hsize     [NDUT];
    logic        hwrite    [NDUT];
    logic [31:0] haddr     [NDUT];
    logic [31:0] hwdata    [NDUT];
    logic [31:0] hrdata    [NDUT];
    logic        hreadyout [NDUT];
    logic        hresp     [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ahb3lite_sram_responder #(
            .HADDR_SIZE (32),
            .HDATA_SIZE (32),
            .MEM_DEPTH  (256),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .HCLK      (clk),
            .HRESETn   (rst_n),
            .HSEL      (hsel[g]),
            .HTRANS    (htrans[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (3'b000),
            .HPROT     (4'b0011),
            .HWRITE    (hwrite[g]),
            .HMASTLOCK (1'b0),
            .HADDR     (haddr[g]),
            .HWDATA    (hwdata[g]),
            .HRDATA    (hrdata[g]),
            .HREADYOUT (hreadyout[g]),
            .HREADY    (hreadyout[g]),
            .HRESP     (hresp[g])
        );
    end

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  trans;
        logic        sel;
        logic        resp;
        logic        chk_rd;
        logic [31:0] rdata;
        int          waits;
    } xfer_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic        resp;
        logic        chk_rd;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    xfer_t seq [$];
    exp_t  sbq [NDUT][$];
    int    dp_cyc [NDUT];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] trans, input logic sel,
                       input logic resp, input logic chk_rd, input logic [31:0] rdata,
                       input int waits);
        xfer_t x;
        x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata; x.trans = trans;
        x.sel = sel; x.resp = resp; x.chk_rd = chk_rd; x.rdata = rdata; x.waits = waits;
        seq.push_back(x);
    endtask

    // Waits for the edge on which the current address/data phase is taken.
    task automatic wait_ready(input int d);
        int budget = 0;
        @(negedge clk);
        while (!hreadyout[d] && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("dut%0d hreadyout timeout", d), 32'(hreadyout[d]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Issues the queued transfers back to back; data of transfer i-1 rides with address i.
    task automatic run_seq(input int d);
        int   n = seq.size();
        exp_t e;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel[d]   = seq[i].sel;
                htrans[d] = seq[i].trans;
                hsize[d]  = seq[i].size;
                hwrite[d] = seq[i].wr;
                haddr[d]  = seq[i].addr;
                if (seq[i].sel && seq[i].trans[1]) begin
                    e.wr = seq[i].wr; e.addr = seq[i].addr; e.resp = seq[i].resp;
                    e.chk_rd = seq[i].chk_rd; e.rdata = seq[i].rdata; e.waits = seq[i].waits;
                    sbq[d].push_back(e);
                end
            end else begin
                hsel[d]   = 1'b0;
                htrans[d] = T_IDL;
            end
            if (i > 0) hwdata[d] = seq[i-1].wdata;
            wait_ready(d);
        end
        seq.delete();
    endtask

    // Monitor: tracks data phases from the bus and compares on completion.
    initial begin
        bit          mon_act [NDUT];
        int          mon_wt  [NDUT];
        logic        r_or    [NDUT];
        logic        r_and   [NDUT];
        bit          done;
        exp_t        e;
        string       tag;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst_n) begin
                    mon_act[d] = 1'b0;
                end else begin
                    done = 1'b0;
                    if (mon_act[d]) begin
                        dp_cyc[d]++;
                        r_or[d]  = r_or[d] | hresp[d];
                        r_and[d] = r_and[d] & hresp[d];
                        if (!hreadyout[d]) begin
                            mon_wt[d]++;
                        end else begin
                            done = 1'b1;
                            if (sbq[d].size() == 0) begin
                                check($sformatf("dut%0d unexpected completion", d), 32'd1, 32'd0);
                            end else begin
                                e   = sbq[d].pop_front();
                                tag = $sformatf("dut%0d %s 0x%03h", d, e.wr ? "wr" : "rd", e.addr);
                                check({tag, " hresp"}, 32'({r_or[d], r_and[d]}), 32'({e.resp, e.resp}));
                                check({tag, " wait cycles"}, 32'(mon_wt[d]), 32'(e.waits));
                                if (e.chk_rd) check({tag, " hrdata"}, hrdata[d], e.rdata);
                            end
                        end
                    end
                    if (hsel[d] && htrans[d][1] && hreadyout[d]) begin
                        mon_act[d] = 1'b1;
                        mon_wt[d]  = 0;
                        r_or[d]    = 1'b0;
                        r_and[d]   = 1'b1;
                    end else if (done) begin
                        mon_act[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int base;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            hsel[d] = 1'b0; htrans[d] = T_IDL; hsize[d] = SZ_W; hwrite[d] = 1'b0;
            haddr[d] = '0; hwdata[d] = '0; dp_cyc[d] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("dut%0d reset hresp", d), 32'(hresp[d]), 32'd0);
            check($sformatf("dut%0d reset hrdata", d), hrdata[d], 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // DUT0: write then read, with HRDATA held through a write data phase.
        add(W, SZ_W, 32'h010, 32'hDEADBEEF, T_NS, 1, 0, 1, 32'h0, 0);
        run_seq(0);
        add(R, SZ_W, 32'h010, 32'h0,        T_NS,  1, 0, 1, 32'hDEADBEEF, 0);
        add(W, SZ_W, 32'h014, 32'h01020304, T_NS,  1, 0, 1, 32'hDEADBEEF, 0);
        add(W, SZ_W, 32'h010, 32'h0,        T_NS,  0, 0, 0, 32'h0, 0);
        add(W, SZ_W, 32'h010, 32'h0,        T_BSY, 1, 0, 0, 32'h0, 0);
        add(R, SZ_W, 32'h010, 32'h0,        T_NS,  1, 0, 1, 32'hDEADBEEF, 0);
        run_seq(0);

        // DUT0: byte lanes, with forwarding on the word read.
        add(W, SZ_W, 32'h020, 32'h00000000, T_NS, 1, 0, 0, 32'h0, 0);
        add(W, SZ_B, 32'h023, 32'hAA000000, T_NS, 1, 0, 0, 32'h0, 0);
        add(W, SZ_H, 32'h020, 32'h00005566, T_NS, 1, 0, 0, 32'h0, 0);
        add(R, SZ_W, 32'h020, 32'h0,        T_NS, 1, 0, 1, 32'hAA005566, 0);
        add(R, SZ_B, 32'h021, 32'h0,        T_NS, 1, 0, 1, 32'hAA005566, 0);
        run_seq(0);

        // DUT0: back-to-back forwarding of a word and a single byte.
        add(W, SZ_W, 32'h040, 32'h12345678, T_NS, 1, 0, 0, 32'h0, 0);
        add(R, SZ_W, 32'h040, 32'h0,        T_NS, 1, 0, 1, 32'h12345678, 0);
        add(W, SZ_B, 32'h041, 32'h0000AB00, T_NS, 1, 0, 0, 32'h0, 0);
        add(R, SZ_W, 32'h040, 32'h0,        T_NS, 1, 0, 1, 32'h1234AB78, 0);
        run_seq(0);

        // DUT0: illegal transfers and the last legal word.
        add(W, SZ_W, 32'h000, 32'h11111111, T_NS, 1, 0, 0, 32'h0, 0);
        add(R, SZ_W, 32'h400, 32'h0,        T_NS, 1, 1, 1, 32'h0, 1);
        add(W, SZ_W, 32'h002, 32'hFFFFFFFF, T_NS, 1, 1, 1, 32'h0, 1);
        add(W, SZ_H, 32'h001, 32'hFFFFFFFF, T_NS, 1, 1, 1, 32'h0, 1);
        add(R, SZ_D, 32'h008, 32'h0,        T_NS, 1, 1, 1, 32'h0, 1);
        add(W, SZ_H, 32'h002, 32'h22220000, T_NS, 1, 0, 1, 32'h0, 0);
        add(R, SZ_W, 32'h000, 32'h0,        T_NS, 1, 0, 1, 32'h22221111, 0);
        add(W, SZ_W, 32'h3FC, 32'hA5A55A5A, T_NS, 1, 0, 0, 32'h0, 0);
        add(R, SZ_W, 32'h3FC, 32'h0,        T_NS, 1, 0, 1, 32'hA5A55A5A, 0);
        run_seq(0);

        // DUT1 (3 wait states): single transfers, error skips waits.
        add(W, SZ_W, 32'h000, 32'h0BADF00D, T_NS, 1, 0, 0, 32'h0, 3);
        add(R, SZ_W, 32'h000, 32'h0,        T_NS, 1, 0, 1, 32'h0BADF00D, 3);
        add(R, SZ_W, 32'h400, 32'h0,        T_NS, 1, 1, 1, 32'h0, 1);
        add(W, SZ_W, 32'h004, 32'h44444444, T_NS, 1, 0, 0, 32'h0, 3);
        add(W, SZ_W, 32'h008, 32'h88888888, T_NS, 1, 0, 0, 32'h0, 3);
        add(W, SZ_W, 32'h00C, 32'hCCCCCCCC, T_NS, 1, 0, 0, 32'h0, 3);
        run_seq(1);

        // DUT1: INCR4 burst of word reads.
        base = dp_cyc[1];
        add(R, SZ_W, 32'h000, 32'h0, T_NS, 1, 0, 1, 32'h0BADF00D, 3);
        add(R, SZ_W, 32'h004, 32'h0, T_SQ, 1, 0, 1, 32'h44444444, 3);
        add(R, SZ_W, 32'h008, 32'h0, T_SQ, 1, 0, 1, 32'h88888888, 3);
        add(R, SZ_W, 32'h00C, 32'h0, T_SQ, 1, 0, 1, 32'hCCCCCCCC, 3);
        run_seq(1);
        check("dut1 INCR4 data-phase cycles", 32'(dp_cyc[1] - base), 32'd16);

        // DUT2 (2 wait states): reset abandons a pending write.
        add(W, SZ_W, 32'h080, 32'h13579BDF, T_NS, 1, 0, 0, 32'h0, 2);
        add(R, SZ_W, 32'h080, 32'h0,        T_NS, 1, 0, 1, 32'h13579BDF, 2);
        run_seq(2);
        hsel[2] = 1'b1; htrans[2] = T_NS; hsize[2] = SZ_W; hwrite[2] = 1'b1; haddr[2] = 32'h080;
        @(posedge clk);
        #1;
        hsel[2] = 1'b0; htrans[2] = T_IDL; hwdata[2] = 32'hCAFEF00D;
        @(negedge clk);
        check("dut2 wait before reset hreadyout", 32'(hreadyout[2]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("dut2 mid-write reset hreadyout", 32'(hreadyout[2]), 32'd1);
        check("dut2 mid-write reset hresp", 32'(hresp[2]), 32'd0);
        check("dut2 mid-write reset hrdata", hrdata[2], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add(R, SZ_W, 32'h080, 32'h0, T_NS, 1, 0, 1, 32'h13579BDF, 2);
        run_seq(2);

        repeat (3) @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d scoreboard drained", d), 32'(sbq[d].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
